// File: rtl/debug_bus_arbiter.sv
// Round-robin arbiter sharing one debug bus port between NUM_REQ requesters.
// One transaction in flight at a time. Each response is routed back to its issuer.
// A timeout error response is produced if the debug unit never answers.
module debug_bus_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] addr_i,
    input  logic [NUM_REQ-1:0]            we_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] wdata_i,
    output logic [NUM_REQ-1:0]            gnt_o,
    output logic [NUM_REQ-1:0]            rvalid_o,
    output logic [DATA_WIDTH-1:0]         rdata_o,
    output logic                          err_o,
    output logic                          dbg_req_o,
    output logic [ADDR_WIDTH-1:0]         dbg_addr_o,
    output logic                          dbg_we_o,
    output logic [DATA_WIDTH-1:0]         dbg_wdata_o,
    input  logic                          dbg_gnt_i,
    input  logic                          dbg_rvalid_i,
    input  logic [DATA_WIDTH-1:0]         dbg_rdata_i
);

    localparam int SW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    // Timer keeps at least one bit so a disabled timeout still elaborates.
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] T_LAST = TW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
    localparam logic [TW-1:0] T_MAX  = {TW{1'b1}};

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t        state, state_nx;
    logic [SW-1:0] sel, sel_nx;
    logic [SW-1:0] last, last_nx;
    logic [SW-1:0] winner;
    logic [TW-1:0] timer, timer_nx;
    logic          found;
    int            idx;

    // Round-robin search: first active request after the last granted requester.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = (int'(last) + i) % NUM_REQ;
            if (!found && req_i[idx]) begin
                winner = SW'(idx);
                found  = 1'b1;
            end
        end
    end

    // Next-state logic and all outputs; outputs are zero unless a state drives them.
    always_comb begin
        state_nx    = state;
        sel_nx      = sel;
        last_nx     = last;
        timer_nx    = timer;
        gnt_o       = '0;
        rvalid_o    = '0;
        rdata_o     = '0;
        err_o       = 1'b0;
        dbg_req_o   = 1'b0;
        dbg_addr_o  = '0;
        dbg_we_o    = 1'b0;
        dbg_wdata_o = '0;
        case (state)
            IDLE: begin
                if (|req_i) begin
                    sel_nx   = winner;
                    state_nx = REQ;
                end
            end
            REQ: begin
                dbg_req_o   = req_i[sel];
                dbg_addr_o  = addr_i[int'(sel)*ADDR_WIDTH +: ADDR_WIDTH];
                dbg_we_o    = we_i[sel];
                dbg_wdata_o = wdata_i[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
                if (!req_i[sel]) begin
                    // Requester withdrew before the bus granted: abort, priority unchanged.
                    state_nx = IDLE;
                end else if (dbg_gnt_i) begin
                    gnt_o[sel] = 1'b1;
                    last_nx    = sel;
                    timer_nx   = '0;
                    state_nx   = RESP;
                end
            end
            RESP: begin
                if (dbg_rvalid_i) begin
                    rvalid_o[sel] = 1'b1;
                    rdata_o       = dbg_rdata_i;
                    state_nx      = IDLE;
                end else if ((TIMEOUT != 0) && (timer == T_LAST)) begin
                    rvalid_o[sel] = 1'b1;
                    err_o         = 1'b1;
                    state_nx      = IDLE;
                end else if (timer != T_MAX) begin
                    timer_nx = timer + 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // State, selection, priority pointer and timeout counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            sel   <= '0;
            last  <= SW'(NUM_REQ - 1);
            timer <= '0;
        end else begin
            state <= state_nx;
            sel   <= sel_nx;
            last  <= last_nx;
            timer <= timer_nx;
        end
    end

endmodule

// File: tb/tb_debug_bus_arbiter.sv
// Scoreboard bench for debug_bus_arbiter with a behavioural debug-unit model.
module tb_debug_bus_arbiter;

    localparam int N  = 2;
    localparam int AW = 15;
    localparam int DW = 32;
    localparam int TO = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_i;
    logic [N*AW-1:0] addr_i;
    logic [N-1:0]    we_i;
    logic [N*DW-1:0] wdata_i;
    logic [N-1:0]    gnt_o;
    logic [N-1:0]    rvalid_o;
    logic [DW-1:0]   rdata_o;
    logic            err_o;
    logic            dbg_req_o;
    logic [AW-1:0]   dbg_addr_o;
    logic            dbg_we_o;
    logic [DW-1:0]   dbg_wdata_o;
    logic            dbg_gnt_i;
    logic            dbg_rvalid_i;
    logic [DW-1:0]   dbg_rdata_i;

    debug_bus_arbiter #(
        .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst), .req_i(req_i), .addr_i(addr_i), .we_i(we_i),
        .wdata_i(wdata_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
        .err_o(err_o), .dbg_req_o(dbg_req_o), .dbg_addr_o(dbg_addr_o),
        .dbg_we_o(dbg_we_o), .dbg_wdata_o(dbg_wdata_o), .dbg_gnt_i(dbg_gnt_i),
        .dbg_rvalid_i(dbg_rvalid_i), .dbg_rdata_i(dbg_rdata_i)
    );

    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {int who; logic [AW-1:0] addr; logic we; logic [DW-1:0] wdata;} gexp_t;
    typedef struct {int who; logic [DW-1:0] data; logic err; int delay;} rexp_t;
    typedef struct {int lat; logic [DW-1:0] data;} plan_t;
    typedef struct {longint at; logic [DW-1:0] data;} sched_t;

    gexp_t  gq[$];
    rexp_t  rq[$];
    plan_t  pq[$];
    sched_t sq[$];
    longint gnt_cycles[$];
    longint gnt_cyc = 0;

    int n_checks = 0;
    int n_fail   = 0;
    int gnt_mode = 2;      // 0 random, 1 never grant, 2 always grant
    int model_last = N - 1;

    logic [AW-1:0] r_addr[N];
    logic          r_we[N];
    logic [DW-1:0] r_wdata[N];

    always_comb begin
        addr_i  = '0;
        we_i    = '0;
        wdata_i = '0;
        for (int k = 0; k < N; k++) begin
            addr_i[k*AW +: AW]  = r_addr[k];
            we_i[k]             = r_we[k];
            wdata_i[k*DW +: DW] = r_wdata[k];
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_vals();
        for (int k = 0; k < N; k++) begin
            r_addr[k]  = AW'($urandom);
            r_we[k]    = 1'($urandom);
            r_wdata[k] = $urandom;
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_gnt"}, 64'(gnt_o), 0);
        chk({tag, "_rvalid"}, 64'(rvalid_o), 0);
        chk({tag, "_rdata"}, 64'(rdata_o), 0);
        chk({tag, "_err"}, 64'(err_o), 0);
        chk({tag, "_dbg_req"}, 64'(dbg_req_o), 0);
    endtask

    // Model: grants rotate through the requesting set starting after the last winner;
    // a response arriving within TO cycles carries data, otherwise an error at TO.
    task automatic issue_round(input logic [N-1:0] subset, input int ntxn, input int fixed_lat,
                               input bit use_data, input logic [DW-1:0] data,
                               input bit hold, input bit chk_start);
        int k;
        int it;
        int lat;
        logic [N-1:0] g;
        gexp_t ge;
        rexp_t r;
        plan_t p;
        k = model_last;
        for (int t = 0; t < ntxn; t++) begin
            for (int s = 1; s <= N; s++) begin
                if (subset[(k + s) % N]) begin
                    k = (k + s) % N;
                    break;
                end
            end
            lat    = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 10));
            p.lat  = lat;
            p.data = use_data ? data : $urandom;
            ge.who = k; ge.addr = r_addr[k]; ge.we = r_we[k]; ge.wdata = r_wdata[k];
            r.who  = k;
            if (lat >= 1 && lat <= TO) begin
                r.data = p.data; r.err = 1'b0; r.delay = lat;
            end else begin
                r.data = '0; r.err = 1'b1; r.delay = TO;
            end
            gq.push_back(ge);
            rq.push_back(r);
            pq.push_back(p);
        end
        model_last = k;
        req_i = subset;
        it = 0;
        while (rq.size() != 0 && it < 400) begin
            @(negedge clk);
            g = gnt_o;
            if (chk_start && it == 0) chk("start_idle_no_req", 64'(dbg_req_o), 0);
            if (chk_start && it == 1) chk("start_req_cycle1", 64'(dbg_req_o), 1);
            @(posedge clk);
            #1;
            if (!hold) req_i = req_i & ~g;
            it++;
        end
        if (rq.size() != 0) begin
            chk("round_budget_outstanding", 64'(rq.size()), 0);
            gq.delete(); rq.delete(); pq.delete();
        end
        req_i = '0;
        repeat (3) tick();
    endtask

    // Debug unit: drives grant per mode and returns responses at scheduled cycles.
    initial begin
        dbg_gnt_i    = 1'b0;
        dbg_rvalid_i = 1'b0;
        dbg_rdata_i  = '0;
        forever begin
            @(posedge clk);
            #1;
            case (gnt_mode)
                0:       dbg_gnt_i = 1'($urandom_range(0, 1));
                1:       dbg_gnt_i = 1'b0;
                default: dbg_gnt_i = 1'b1;
            endcase
            while (sq.size() != 0 && sq[0].at < cyc) void'(sq.pop_front());
            if (sq.size() != 0 && sq[0].at == cyc) begin
                dbg_rvalid_i = 1'b1;
                dbg_rdata_i  = sq[0].data;
                void'(sq.pop_front());
            end else begin
                dbg_rvalid_i = 1'b0;
                dbg_rdata_i  = $urandom;
            end
        end
    end

    // Debug unit: on each accepted grant, schedule its answer (lat 0 = never).
    initial begin
        plan_t  p;
        sched_t s;
        forever begin
            @(negedge clk);
            if (!rst && gnt_o != 0 && pq.size() != 0) begin
                p = pq.pop_front();
                if (p.lat > 0) begin
                    s.at = cyc + p.lat;
                    s.data = p.data;
                    sq.push_back(s);
                end
            end
        end
    end

    // Monitor: compares every grant and response against the scoreboard queues.
    initial begin
        gexp_t ge;
        rexp_t r;
        logic [N-1:0] oh;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (gnt_o != 0) begin
                    if (gq.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL unexpected_gnt: actual %b required 0", gnt_o);
                    end else begin
                        ge = gq.pop_front();
                        oh = '0; oh[ge.who] = 1'b1;
                        chk("gnt_onehot", 64'(gnt_o), 64'(oh));
                        chk("gnt_dbg_req", 64'(dbg_req_o), 1);
                        chk("gnt_addr", 64'(dbg_addr_o), 64'(ge.addr));
                        chk("gnt_we", 64'(dbg_we_o), 64'(ge.we));
                        chk("gnt_wdata", 64'(dbg_wdata_o), 64'(ge.wdata));
                    end
                    gnt_cyc = cyc;
                    gnt_cycles.push_back(cyc);
                end
                if (rvalid_o != 0) begin
                    if (rq.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL unexpected_rvalid: actual %b required 0", rvalid_o);
                    end else begin
                        r = rq.pop_front();
                        oh = '0; oh[r.who] = 1'b1;
                        chk("rvalid_onehot", 64'(rvalid_o), 64'(oh));
                        chk("resp_rdata", 64'(rdata_o), 64'(r.data));
                        chk("resp_err", 64'(err_o), 64'(r.err));
                        chk("resp_latency", 64'(cyc - gnt_cyc), 64'(r.delay));
                    end
                end else begin
                    chk("idle_rdata_err_zero", 64'({err_o, rdata_o}), 0);
                end
            end
        end
    end

    initial begin
        #500000;
        n_fail++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        int found;
        rand_vals();
        req_i = '1;
        gnt_mode = 2;
        // Reset state with busy-looking inputs.
        @(negedge clk);
        check_all_zero("in_reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        req_i = '0;
        @(negedge clk);
        check_all_zero("after_reset");
        tick();

        // Write from requester 0.
        rand_vals();
        r_addr[0] = 15'h1000; r_we[0] = 1'b1; r_wdata[0] = 32'h0000CAFE;
        issue_round(2'b01, 1, 1, 1'b0, '0, 1'b0, 1'b1);

        // Read from requester 1.
        rand_vals();
        r_we[1] = 1'b0;
        issue_round(2'b10, 1, 2, 1'b1, 32'h12345678, 1'b0, 1'b0);

        // Abort: requester 0 withdraws while the bus withholds its grant.
        gnt_mode = 1;
        rand_vals();
        req_i = 2'b01;
        @(negedge clk);
        chk("abort_idle_first", 64'(dbg_req_o), 0);
        tick();
        @(negedge clk);
        chk("abort_req_shown", 64'(dbg_req_o), 1);
        gnt_mode = 2;
        tick();
        req_i = '0;
        @(negedge clk);
        chk("abort_no_gnt", 64'(gnt_o), 0);
        chk("abort_req_dropped", 64'(dbg_req_o), 0);
        tick();
        @(negedge clk);
        chk("abort_back_idle", 64'(dbg_req_o), 0);
        tick();
        rand_vals();
        issue_round(2'b11, 2, 1, 1'b0, '0, 1'b0, 1'b0);

        // Continuous requests from both, answers one cycle after grant.
        rand_vals();
        gnt_cycles.delete();
        issue_round(2'b11, 4, 1, 1'b0, '0, 1'b1, 1'b0);
        chk("b2b_count", 64'(gnt_cycles.size()), 4);
        for (int i = 1; i < gnt_cycles.size(); i++)
            chk("b2b_spacing", 64'(gnt_cycles[i] - gnt_cycles[i-1]), 3);

        // Timeouts with late answers that must be ignored.
        rand_vals();
        issue_round(2'b01, 1, 9, 1'b0, '0, 1'b0, 1'b0);
        rand_vals();
        issue_round(2'b10, 1, 10, 1'b0, '0, 1'b0, 1'b0);
        rand_vals();
        issue_round(2'b01, 1, 8, 1'b0, '0, 1'b0, 1'b0);

        // Reset while waiting for a response.
        rand_vals();
        begin
            gexp_t ge;
            plan_t p;
            ge.who = 0; ge.addr = r_addr[0]; ge.we = r_we[0]; ge.wdata = r_wdata[0];
            p.lat = 6; p.data = $urandom;
            gq.push_back(ge);
            pq.push_back(p);
        end
        req_i = 2'b01;
        found = 0;
        for (int i = 0; i < 10 && found == 0; i++) begin
            @(negedge clk);
            if (gnt_o != 0) found = 1;
        end
        chk("rst_test_gnt_seen", 64'(found), 1);
        tick();
        req_i = 2'b11;
        rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        @(negedge clk);
        check_all_zero("rst_held");
        tick();
        tick();
        rst = 1'b0;
        req_i = '0;
        model_last = N - 1;
        gq.delete(); rq.delete(); pq.delete();
        repeat (8) tick();
        rand_vals();
        issue_round(2'b11, 2, 2, 1'b0, '0, 1'b0, 1'b0);

        // Randomized rounds.
        for (int r = 0; r < 40; r++) begin
            logic [N-1:0] sub;
            gnt_mode = ($urandom_range(0, 1) == 0) ? 0 : 2;
            sub = N'($urandom_range(1, 3));
            rand_vals();
            issue_round(sub, $countones(sub), -1, 1'b0, '0, 1'b0, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
